uart_tx_fifo: RTL and testbench

- Transmit-side buffer that sits directly upstream of the UART core.
- Accepts bytes from the bus-side register logic into a synchronous FIFO.
- Launches each byte into the UART core with a one-cycle transmit pulse, then tracks the core's busy flag so exactly one byte is in flight at a time.
- Lets software queue a burst without polling the UART's is_transmitting status.

---
 rtl/uart_tx_fifo.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO feeding the UART core: queues bytes and launches one at a time.
// Optional clear-to-send gating is enabled with UART_TX_FIFO_CTS_EN.
module uart_tx_fifo #(
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned LAUNCH_TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_stb,
    input  logic [7:0]            wr_data,
    input  logic                  flush,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  tx_drop,
    output logic                  uart_transmit,
    output logic [7:0]            uart_tx_byte,
    input  logic                  uart_is_transmitting
`ifdef UART_TX_FIFO_CTS_EN
    ,
    input  logic                  cts_n
`endif
);

    localparam int unsigned AW    = ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned TW    = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_BUSY = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic          r_transmit;
    logic          r_tx_drop;
    logic [7:0]    r_tx_byte;

    state_t        w_state_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic          w_transmit_nxt;
    logic          w_tx_drop_nxt;
    logic [7:0]    w_tx_byte_nxt;
    logic          w_pop;
    logic          w_wr_ok;
    logic          w_full;
    logic          w_empty;
    logic          w_cts_ok;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == CW'(0));
    // A flush cycle ignores the write and suppresses any pop.
    assign w_wr_ok = wr_stb && !w_full && !flush;

`ifdef UART_TX_FIFO_CTS_EN
    logic [1:0] r_cts_sync;

    // Two-flop synchroniser; resets to "not clear".
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cts_sync <= 2'b11;
        end else begin
            r_cts_sync <= {r_cts_sync[0], cts_n};
        end
    end

    assign w_cts_ok = !r_cts_sync[1];
`else
    assign w_cts_ok = 1'b1;
`endif

    // Storage array carries no reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= wr_stb && w_full;
            if (flush) begin
                r_rptr  <= r_wptr;
                r_count <= '0;
            end else begin
                if (w_wr_ok) begin
                    r_wptr <= r_wptr + AW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + AW'(1);
                end
                r_count <= r_count + CW'(w_wr_ok) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_transmit <= 1'b0;
            r_tx_drop  <= 1'b0;
            r_tx_byte  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_transmit <= w_transmit_nxt;
            r_tx_drop  <= w_tx_drop_nxt;
            r_tx_byte  <= w_tx_byte_nxt;
        end
    end

    // Launch FSM: one byte in flight, tracked via the core's busy flag.
    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_transmit_nxt = 1'b0;
        w_tx_drop_nxt  = 1'b0;
        w_tx_byte_nxt  = r_tx_byte;
        w_pop          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && w_cts_ok && !flush) begin
                    w_pop          = 1'b1;
                    w_transmit_nxt = 1'b1;
                    w_tx_byte_nxt  = r_mem[r_rptr];
                    w_timer_nxt    = '0;
                    w_state_nxt    = ST_WAIT_BUSY;
                end
            end
            ST_WAIT_BUSY: begin
                if (uart_is_transmitting) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (r_timer == TW'(LAUNCH_TIMEOUT - 1)) begin
                    w_tx_drop_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!uart_is_transmitting) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign full          = w_full;
    assign empty         = w_empty;
    assign count         = r_count;
    assign overflow      = r_overflow;
    assign tx_drop       = r_tx_drop;
    assign uart_transmit = r_transmit;
    assign uart_tx_byte  = r_tx_byte;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple UART busy-flag model.
// Build with UART_TX_FIFO_CTS_EN to also exercise clear-to-send gating.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic       wr_stb;
    logic [7:0] wr_data;
    logic       flush;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       tx_drop;
    logic       uart_transmit;
    logic [7:0] uart_tx_byte;
    logic       uart_is_transmitting;
    logic       cts_n;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] emitted[$];
    int         n_strobes   = 0;
    logic       model_respond = 1'b1;
    int         busy_len    = 80;
    int         dly         = 0;
    int         bcnt        = 0;
    int         base;

    uart_tx_fifo #(.ADDR_WIDTH(4), .LAUNCH_TIMEOUT(8)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .wr_stb               (wr_stb),
        .wr_data              (wr_data),
        .flush                (flush),
        .full                 (full),
        .empty                (empty),
        .count                (count),
        .overflow             (overflow),
        .tx_drop              (tx_drop),
        .uart_transmit        (uart_transmit),
        .uart_tx_byte         (uart_tx_byte),
        .uart_is_transmitting (uart_is_transmitting)
`ifdef UART_TX_FIFO_CTS_EN
        ,
        .cts_n                (cts_n)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART model: busy rises two cycles after the strobe, lasts busy_len cycles.
    initial begin
        uart_is_transmitting = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                uart_is_transmitting = 1'b0;
                dly  = 0;
                bcnt = 0;
            end else if (uart_transmit) begin
                emitted.push_back(uart_tx_byte);
                n_strobes++;
                if (model_respond) dly = 1;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    uart_is_transmitting = 1'b1;
                    bcnt = busy_len;
                end
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) uart_is_transmitting = 1'b0;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_count"},    32'(count),         32'd0);
        chk({pfx, "_empty"},    32'(empty),         32'd1);
        chk({pfx, "_full"},     32'(full),          32'd0);
        chk({pfx, "_overflow"}, 32'(overflow),      32'd0);
        chk({pfx, "_tx_drop"},  32'(tx_drop),       32'd0);
        chk({pfx, "_transmit"}, 32'(uart_transmit), 32'd0);
        chk({pfx, "_tx_byte"},  32'(uart_tx_byte),  32'd0);
    endtask

    initial begin
        rst = 1'b1; wr_stb = 1'b0; wr_data = 8'h00; flush = 1'b0; cts_n = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(3);
        chk_reset("rst");

        // Single byte
        emitted.delete(); n_strobes = 0; busy_len = 80;
        wr_stb = 1'b1; wr_data = 8'hA5;
        tick();
        chk("t1_count_after_E", 32'(count), 32'd1);
        chk("t1_no_strobe_yet", 32'(uart_transmit), 32'd0);
        wr_stb = 1'b0;
        tick();
        chk("t1_strobe", 32'(uart_transmit), 32'd1);
        chk("t1_byte", 32'(uart_tx_byte), 32'hA5);
        chk("t1_count0", 32'(count), 32'd0);
        tick();
        chk("t1_strobe_1cyc", 32'(uart_transmit), 32'd0);
        tick(90);
        chk("t1_nstrobes", 32'(n_strobes), 32'd1);
        chk("t1_empty", 32'(empty), 32'd1);
        chk("t1_byte_hold", 32'(uart_tx_byte), 32'hA5);

        // Burst and overflow while the UART is busy with a dummy byte
        emitted.delete(); n_strobes = 0; busy_len = 40;
        wr_stb = 1'b1; wr_data = 8'hEE;
        tick();
        wr_stb = 1'b0;
        tick(4);
        for (int i = 0; i < 17; i++) begin
            wr_stb = 1'b1; wr_data = 8'(i);
            tick();
            if (i == 14) chk("t2_not_full_15", 32'(full), 32'd0);
            if (i == 15) begin
                chk("t2_full_16", 32'(full), 32'd1);
                chk("t2_count_16", 32'(count), 32'd16);
                chk("t2_no_ovf_yet", 32'(overflow), 32'd0);
            end
        end
        chk("t2_overflow", 32'(overflow), 32'd1);
        chk("t2_count_held", 32'(count), 32'd16);
        wr_stb = 1'b0;
        tick();
        chk("t2_overflow_once", 32'(overflow), 32'd0);
        tick(900);
        chk("t2_nstrobes", 32'(n_strobes), 32'd17);
        chk("t2_dummy", 32'(emitted[0]), 32'hEE);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t2_order_%0d", i), 32'(emitted[i+1]), 32'(i));
        end
        chk("t2_empty", 32'(empty), 32'd1);

        // Simultaneous write and pop in the launch cycle
        emitted.delete(); n_strobes = 0; busy_len = 10;
        wr_stb = 1'b1; wr_data = 8'h20; tick();
        wr_data = 8'h21; tick();
        wr_data = 8'h22; tick();
        wr_data = 8'h23; tick();
        wr_stb = 1'b0;
        tick(10);
        chk("t3_count3", 32'(count), 32'd3);
        chk("t3_idle_no_strobe", 32'(uart_transmit), 32'd0);
        wr_stb = 1'b1; wr_data = 8'h24;
        tick();
        wr_stb = 1'b0;
        chk("t3_launch", 32'(uart_transmit), 32'd1);
        chk("t3_launch_byte", 32'(uart_tx_byte), 32'h21);
        chk("t3_count_same", 32'(count), 32'd3);
        tick(100);
        chk("t3_nstrobes", 32'(n_strobes), 32'd5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t3_order_%0d", i), 32'(emitted[i]), 32'h20 + 32'(i));
        end

        // Flush with one byte in flight
        emitted.delete(); n_strobes = 0; busy_len = 20;
        for (int i = 0; i < 5; i++) begin
            wr_stb = 1'b1; wr_data = 8'h30 + 8'(i);
            tick();
        end
        wr_stb = 1'b0;
        chk("t4_count4", 32'(count), 32'd4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_count0", 32'(count), 32'd0);
        chk("t4_empty", 32'(empty), 32'd1);
        tick(60);
        chk("t4_nstrobes", 32'(n_strobes), 32'd1);
        chk("t4_inflight", 32'(emitted[0]), 32'h30);
        chk("t4_busy_done", 32'(uart_is_transmitting), 32'd0);

        // Launch timeout: the UART never raises busy
        emitted.delete(); n_strobes = 0; model_respond = 1'b0;
        wr_stb = 1'b1; wr_data = 8'h41; tick();
        wr_data = 8'h42; tick();
        wr_stb = 1'b0;
        chk("t5_strobe1", 32'(uart_transmit), 32'd1);
        chk("t5_byte1", 32'(uart_tx_byte), 32'h41);
        tick(7);
        chk("t5_no_drop_early", 32'(tx_drop), 32'd0);
        tick();
        chk("t5_drop", 32'(tx_drop), 32'd1);
        tick();
        chk("t5_drop_once", 32'(tx_drop), 32'd0);
        chk("t5_strobe2", 32'(uart_transmit), 32'd1);
        chk("t5_byte2", 32'(uart_tx_byte), 32'h42);
        tick(10);
        chk("t5_nstrobes", 32'(n_strobes), 32'd2);
        model_respond = 1'b1;

        // Reset while waiting for the UART to finish
        busy_len = 50;
        wr_stb = 1'b1; wr_data = 8'h55; tick();
        wr_data = 8'h56; tick();
        wr_data = 8'h57; tick();
        wr_stb = 1'b0;
        tick(5);
        chk("t6_busy", 32'(uart_is_transmitting), 32'd1);
        chk("t6_count2", 32'(count), 32'd2);
        rst = 1'b1;
        tick();
        chk_reset("t6");
        rst = 1'b0;
        tick(5);
        chk("t6_stays_empty", 32'(count), 32'd0);

`ifdef UART_TX_FIFO_CTS_EN
        // Clear-to-send gating
        emitted.delete(); n_strobes = 0; busy_len = 20;
        cts_n = 1'b1;
        tick(3);
        wr_stb = 1'b1; wr_data = 8'h61; tick();
        wr_data = 8'h62; tick();
        wr_stb = 1'b0;
        tick(100);
        chk("t7_held", 32'(n_strobes), 32'd0);
        chk("t7_count2", 32'(count), 32'd2);
        cts_n = 1'b0;
        tick(2);
        chk("t7_no_strobe_2", 32'(uart_transmit), 32'd0);
        tick();
        chk("t7_strobe_3", 32'(uart_transmit), 32'd1);
        chk("t7_byte", 32'(uart_tx_byte), 32'h61);
        tick(3);
        cts_n = 1'b1;
        tick(60);
        chk("t7_one_strobe", 32'(n_strobes), 32'd1);
        chk("t7_second_held", 32'(count), 32'd1);
        cts_n = 1'b0;
        tick(40);
        chk("t7_second_sent", 32'(n_strobes), 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
